// File: rtl/hamming1511_pkg.sv
// Shared constants, occupancy state and the Hamming(15,11) encode function
// for the streaming encoder and anything that needs to model it.
package hamming1511_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;
    localparam logic [3:0] POS_NONE = 4'd15;

    // Codeword index (Hamming position - 1) that carries data bit d[i]
    localparam logic [3:0] DATA_IDX [DATA_W] = '{
        4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14
    };

    localparam logic [CODE_W-1:0] P0_MASK = 15'h5554;
    localparam logic [CODE_W-1:0] P1_MASK = 15'h6664;
    localparam logic [CODE_W-1:0] P3_MASK = 15'h7870;
    localparam logic [CODE_W-1:0] P7_MASK = 15'h7F00;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c[DATA_IDX[i]] = data[i];
        end
        c[0] = ^(c & P0_MASK);
        c[1] = ^(c & P1_MASK);
        c[3] = ^(c & P3_MASK);
        c[7] = ^(c & P7_MASK);
        return c;
    endfunction

endpackage

// File: rtl/hamming1511_skid.sv
// Two-entry valid/ready register slice: output register plus skid register,
// registered in_ready so out_ready never reaches in_ready combinationally.
module hamming1511_skid
    import hamming1511_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t   state;
    logic         rdy_p1;
    logic         vld_p1;
    logic [W-1:0] out_data_p1;
    logic [W-1:0] skid_data_p1;
    logic         in_acc;
    logic         out_acc;

    assign in_acc    = in_valid & rdy_p1;
    assign out_acc   = vld_p1 & out_ready;
    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;

    // ---- stage p1: OUT / SKID registers and occupancy ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            rdy_p1       <= 1'b0;
            vld_p1       <= 1'b0;
            out_data_p1  <= '0;
            skid_data_p1 <= '0;
        end else begin
            rdy_p1 <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_acc) begin
                        out_data_p1 <= in_data;
                        vld_p1      <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_acc && !out_acc) begin
                        skid_data_p1 <= in_data;
                        rdy_p1       <= 1'b0;
                        state        <= TWO;
                    end else if (out_acc && !in_acc) begin
                        vld_p1 <= 1'b0;
                        state  <= EMPTY;
                    end else if (in_acc && out_acc) begin
                        out_data_p1 <= in_data;
                    end
                end
                TWO: begin
                    if (out_acc) begin
                        out_data_p1 <= skid_data_p1;
                        state       <= ONE;
                    end else begin
                        rdy_p1 <= 1'b0;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/hamming1511_enc_pipe.sv
// Streaming Hamming(15,11) encoder with skid-buffered output.
// Optional single-bit error injection: define HAMMING_ERR_INJECT_EN.
module hamming1511_enc_pipe
    import hamming1511_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_injected,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
    output logic [CNT_W-1:0]  word_count
);

    localparam int PAY_W = CODE_W + 1;

    logic [CODE_W-1:0] code_p0;
    logic              inj_p0;
    logic [CNT_W-1:0]  cnt_p1;

    // ---- stage p0: combinational encode and optional bit flip ----
`ifdef HAMMING_ERR_INJECT_EN
    always_comb begin
        code_p0 = encode(in_data);
        inj_p0  = 1'b0;
        if (inj_en && (inj_pos != POS_NONE)) begin
            code_p0 = code_p0 ^ (CODE_W'(1) << inj_pos);
            inj_p0  = 1'b1;
        end
    end
`else
    logic unused_inj;
    assign unused_inj = ^{inj_en, inj_pos};
    assign code_p0    = encode(in_data);
    assign inj_p0     = 1'b0;
`endif

    hamming1511_skid #(
        .W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({inj_p0, code_p0}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_injected, out_code})
    );

    // ---- stage p1: delivered-codeword counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (out_valid && out_ready) begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign word_count = cnt_p1;

endmodule

// File: tb/tb_hamming1511_enc_pipe.sv
// Directed and randomised self-checking bench for hamming1511_enc_pipe.
module tb_hamming1511_enc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        inj_en = 1'b0;
    logic [3:0]  inj_pos = 4'd15;

    logic        in_ready, out_valid, out_injected;
    logic [14:0] out_code;
    logic [15:0] word_count;

    logic        in_ready4, out_valid4, out_injected4;
    logic [14:0] out_code4;
    logic [3:0]  word_count4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hamming1511_enc_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_injected(out_injected), .inj_en(inj_en),
        .inj_pos(inj_pos), .word_count(word_count)
    );

    hamming1511_enc_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_code(out_code4), .out_injected(out_injected4), .inj_en(inj_en),
        .inj_pos(inj_pos), .word_count(word_count4)
    );

    // Reference model built from position arithmetic rather than masks
    function automatic logic [3:0] ref_syndrome(input logic [14:0] c);
        logic [3:0] s;
        s = '0;
        for (int p = 1; p <= 15; p++) begin
            if (c[p-1]) s = s ^ p[3:0];
        end
        return s;
    endfunction

    function automatic logic [14:0] ref_encode(input logic [10:0] d);
        logic [14:0] c;
        logic [3:0]  s;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        s = ref_syndrome(c);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) c[(1 << b) - 1] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [10:0] ref_decode(input logic [14:0] c_in);
        logic [14:0] c;
        logic [3:0]  s;
        logic [10:0] d;
        int k;
        c = c_in;
        s = ref_syndrome(c);
        if (s != 4'd0) c[s - 4'd1] = ~c[s - 4'd1];
        d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        inj_en = 1'b0;
        inj_pos = 4'd15;
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 15'h0000 ||
            out_injected !== 1'b0 || word_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%b ready=%b code=%h inj=%b cnt=%0d want 0 0 0000 0 0",
                     out_valid, in_ready, out_code, out_injected, word_count);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] din [4]  = '{11'h000, 11'h7FF, 11'h001, 11'h010};
        logic [14:0] dexp [4] = '{15'h0000, 15'h7FFF, 15'h0007, 15'h0181};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = din[i];
            step();
            total++;
            if (out_valid !== 1'b1 || out_code !== dexp[i]) begin
                bad++;
                $display("FAIL b2b_word%0d: valid=%b code=%h want 1 %h", i, out_valid, out_code, dexp[i]);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (word_count !== 16'd4 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count: cnt=%0d valid=%b want 4 0", word_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] w [3]   = '{11'h001, 11'h010, 11'h7FF};
        logic [14:0] e [3]   = '{15'h0007, 15'h0181, 15'h7FFF};
        logic [15:0] cnt0;
        cnt0 = word_count;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = w[0];
        step();
        total++;
        if (in_ready !== 1'b1 || out_code !== e[0]) begin
            bad++;
            $display("FAIL bp_first: ready=%b code=%h want 1 %h", in_ready, out_code, e[0]);
        end
        in_data = w[1];
        step();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: in_ready=%b want 0", in_ready);
        end
        in_data = w[2];
        repeat (3) step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== e[0]) begin
            bad++;
            $display("FAIL bp_stall: ready=%b valid=%b code=%h want 0 1 %h", in_ready, out_valid, out_code, e[0]);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_code !== e[1]) begin
            bad++;
            $display("FAIL bp_drain1: ready=%b code=%h want 1 %h", in_ready, out_code, e[1]);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_code !== e[2]) begin
            bad++;
            $display("FAIL bp_drain2: valid=%b code=%h want 1 %h", out_valid, out_code, e[2]);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || word_count !== cnt0 + 16'd3) begin
            bad++;
            $display("FAIL bp_done: valid=%b cnt=%0d want 0 %0d", out_valid, word_count, cnt0 + 16'd3);
        end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 11'h7FF;
        step();
        in_data = 11'h001;
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || word_count === 16'd0) begin
            bad++;
            $display("FAIL rst2_setup: ready=%b cnt=%0d want 0 nonzero", in_ready, word_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || word_count !== 16'd0 || in_ready !== 1'b0 || out_code !== 15'h0000) begin
            bad++;
            $display("FAIL rst2_async: valid=%b cnt=%0d ready=%b code=%h want 0 0 0 0000",
                     out_valid, word_count, in_ready, out_code);
        end
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst2_stale: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 11'h010;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_code !== 15'h0181) begin
            bad++;
            $display("FAIL rst2_after: valid=%b code=%h want 1 0181", out_valid, out_code);
        end
        step();
        total++;
        if (word_count !== 16'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst2_count: cnt=%0d valid=%b want 1 0", word_count, out_valid);
        end
    endtask

    task automatic test_random();
        logic [10:0] q [$];
        logic [14:0] exp_code;
        logic [14:0] held_code;
        logic        held = 1'b0;
        int pushed = 0;
        int cycles = 0;
        while ((pushed < 10000 || q.size() != 0) && cycles < 60000) begin
            in_valid = (pushed < 10000) && ($urandom_range(0, 3) != 0);
            in_data = 11'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_code !== held_code) begin
                    bad++;
                    $display("FAIL rand_stable: valid=%b code=%h want 1 %h", out_valid, out_code, held_code);
                end
            end
            if (out_valid && out_ready) begin
                exp_code = (q.size() != 0) ? ref_encode(q[0]) : 15'h0000;
                total++;
                if (q.size() == 0 || out_code !== exp_code || ref_syndrome(out_code) !== 4'd0) begin
                    bad++;
                    $display("FAIL rand_word: code=%h want %h qsize=%0d", out_code, exp_code, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            held = out_valid && !out_ready;
            held_code = out_code;
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                pushed++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        total++;
        if (q.size() != 0 || pushed != 10000) begin
            bad++;
            $display("FAIL rand_drain: left=%0d pushed=%0d want 0 10000", q.size(), pushed);
        end
        repeat (2) step();
    endtask

    task automatic test_inject();
        logic [14:0] e_code;
        logic        e_inj;
`ifdef HAMMING_ERR_INJECT_EN
        e_code = 15'h0003;
        e_inj = 1'b1;
`else
        e_code = 15'h0007;
        e_inj = 1'b0;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 11'h001;
        inj_en = 1'b1;
        inj_pos = 4'd2;
        step();
        total++;
        if (out_code !== e_code || out_injected !== e_inj || ref_decode(out_code) !== 11'h001) begin
            bad++;
            $display("FAIL inj_pos2: code=%h inj=%b dec=%h want %h %b 001",
                     out_code, out_injected, ref_decode(out_code), e_code, e_inj);
        end
        inj_pos = 4'd15;
        step();
        total++;
        if (out_code !== 15'h0007 || out_injected !== 1'b0) begin
            bad++;
            $display("FAIL inj_none: code=%h inj=%b want 0007 0", out_code, out_injected);
        end
        inj_en = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        test_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 11'h055;
        repeat (17) step();
        in_valid = 1'b0;
        step();
        total++;
        if (word_count4 !== 4'd1 || word_count !== 16'd17) begin
            bad++;
            $display("FAIL wrap_count: cnt4=%0d cnt16=%0d want 1 17", word_count4, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_in_two();
        test_random();
        test_inject();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
